// File: rtl/adder16_result_corrector.sv
// rtl/adder16_result_corrector.sv - recomputes an exact 16-bit sum slice by slice and flags approximate-adder errors
module adder16_result_corrector #(
  parameter int SLICE_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [15:0] add1_i,
  input  logic [15:0] add2_i,
  input  logic [16:0] approx_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [16:0] result_o,
  output logic        err_o,
  output logic [16:0] err_mask_o,
  input  logic        clr_cnt_i,
  output logic [15:0] err_cnt_o
);

  localparam int N_STEPS = 16 / SLICE_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q;
  logic [3:0]         step_q;
  logic               carry_q;
  logic [15:0]        a1_q;
  logic [15:0]        a2_q;
  logic [16:0]        approx_q;
  logic [16:0]        result_q;
  logic               err_q;
  logic [16:0]        mask_q;
  logic [15:0]        err_cnt_q;

  logic [3:0]         off;
  logic [SLICE_W-1:0] sl1;
  logic [SLICE_W-1:0] sl2;
  logic [SLICE_W:0]   sum;
  logic [15:0]        res_nxt;
  logic [16:0]        final_res;
  logic [16:0]        final_mask;
  logic               finish;
  logic               new_err;

  always_comb begin
    off        = 4'(32'(step_q) * SLICE_W);
    sl1        = a1_q[off +: SLICE_W];
    sl2        = a2_q[off +: SLICE_W];
    sum        = {1'b0, sl1} + {1'b0, sl2} + {{SLICE_W{1'b0}}, carry_q};
    res_nxt    = result_q[15:0];
    res_nxt[off +: SLICE_W] = sum[SLICE_W-1:0];
    final_res  = {sum[SLICE_W], res_nxt};
    final_mask = approx_q ^ final_res;
    new_err    = |final_mask;
    finish     = (state_q == CALC) && (step_q == 4'(N_STEPS - 1));
  end

  assign ready_o    = (state_q == IDLE);
  assign valid_o    = (state_q == DONE);
  assign result_o   = result_q;
  assign err_o      = err_q;
  assign err_mask_o = mask_q;
  assign err_cnt_o  = err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      step_q   <= '0;
      carry_q  <= 1'b0;
      a1_q     <= '0;
      a2_q     <= '0;
      approx_q <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      mask_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            a1_q     <= add1_i;
            a2_q     <= add2_i;
            approx_q <= approx_i;
            carry_q  <= 1'b0;
            step_q   <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          carry_q <= sum[SLICE_W];
          step_q  <= step_q + 4'd1;
          if (finish) begin
            result_q <= final_res;
            mask_q   <= final_mask;
            err_q    <= new_err;
            state_q  <= DONE;
          end else begin
            result_q[15:0] <= res_nxt;
          end
        end
        DONE: begin
          // Release to IDLE only; a new triple is taken on a later edge.
          if (ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (clr_cnt_i) begin
      err_cnt_q <= '0;
    end else if (finish && new_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

endmodule

// File: doc/adder16_result_corrector.md
ADDER16_RESULT_CORRECTOR -- requirements
Module: adder16_result_corrector

Interface
REQ-001 Parameter SLICE_W, default 4, bits of exact sum computed per clock; legal values 1, 2, 4, 8, 16; N_STEPS = 16/SLICE_W.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 valid_i  input  1  upstream offers an operand/result triple.
REQ-005 ready_o  output  1  block can accept a triple.
REQ-006 add1_i  input  16  first addend fed to the approximate 16-bit adder.
REQ-007 add2_i  input  16  second addend fed to the approximate 16-bit adder.
REQ-008 approx_i  input  17  result produced by the approximate adder for add1_i/add2_i.
REQ-009 valid_o  output  1  corrected result available.
REQ-010 ready_i  input  1  downstream accepts result.
REQ-011 result_o  output  17  exact sum add1_i + add2_i (bit 16 = carry out).
REQ-012 err_o  output  1  approx_i differed from exact sum.
REQ-013 err_mask_o  output  17  bitwise XOR of approx_i and exact sum.
REQ-014 clr_cnt_i  input  1  synchronous clear of err_cnt_o.
REQ-015 err_cnt_o  output  16  saturating count of erroneous transactions.

Function
REQ-016 FSM states SHALL be IDLE, CALC, DONE; ready_o = 1 only in IDLE; valid_o = 1 only in DONE.
REQ-017 Accept when valid_i & ready_o at an edge: capture add1_i, add2_i, approx_i into internal registers, clear carry register to 0, step counter to 0, go to CALC.
REQ-018 Inputs SHALL be ignored outside acceptance edges; changes during CALC/DONE have no effect.
REQ-019 In CALC each edge SHALL add slice k (bits k*SLICE_W .. k*SLICE_W+SLICE_W-1) of captured addends plus carry register, store sum slice into result register, update carry, increment k.
REQ-020 On the edge completing slice N_STEPS-1: store final carry as result bit 16, compute err_mask = approx ^ result, err = |err_mask, go to DONE.
REQ-021 Latency SHALL be exactly N_STEPS edges from acceptance edge to valid_o high (4 for default).
REQ-022 In DONE, result_o, err_o, err_mask_o SHALL be stable until valid_o & ready_i; on that edge go to IDLE; no new acceptance on the same edge.
REQ-023 result_o, err_o, err_mask_o SHALL hold last values in IDLE and CALC only as don't-care; verification checks them only while valid_o = 1.
REQ-024 err_cnt_o SHALL increment by 1 on the edge entering DONE when err = 1, saturating at 0xFFFF.
REQ-025 clr_cnt_i = 1 SHALL set err_cnt_o to 0 on that edge, taking priority over a simultaneous increment.
REQ-026 Arithmetic SHALL be unsigned modulo 2^17; no overflow flag.

Reset
REQ-027 rst_ni low SHALL immediately force state IDLE, ready_o 1, valid_o 0, result_o 0, err_o 0, err_mask_o 0, err_cnt_o 0, carry and step counter 0.
REQ-028 Reset mid-CALC or in DONE SHALL abandon the transaction; no result emitted after release; first edge after release with valid_i=1 accepts normally.

Verification
REQ-029 add1 0xFFFF, add2 0x0001, approx 0x10000, ready_i 1 -> after 4 edges valid_o 1, result_o 0x10000, err_o 0, err_mask_o 0, err_cnt_o 0.
REQ-030 add1 0x00FF, add2 0x0001, approx 0x00000 -> result_o 0x00100, err_o 1, err_mask_o 0x00100, err_cnt_o 1.
REQ-031 ready_i held 0 for 10 cycles in DONE -> valid_o and outputs stable, ready_o 0, valid_i pulses ignored; ready_i 1 -> IDLE next edge.
REQ-032 rst_ni pulsed low after 2 CALC edges -> outputs at reset values asynchronously, no valid_o afterwards, next transaction 0x1234+0x4321 -> 0x05555.
REQ-033 Preload err_cnt_o to 0xFFFE via erroneous transactions, two more errors -> 0xFFFF held; error transaction with clr_cnt_i on DONE-entry edge -> 0.
REQ-034 Random 10k triples with approx_i from the approximate adder model, random ready_i -> result_o matches golden add, err_cnt_o equals golden mismatch count.
